// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: circular instruction-byte queue between the fetch response
// bus and the x86 decoder. It accepts 8-byte beats, drops the leading bytes of
// a redirected stream, and presents a 15-byte little-endian window at the head.
module fetch_byte_queue #(
   parameter int DEPTH_BYTES  = 128,
   parameter int BEAT_BYTES   = 8,
   parameter int WINDOW_BYTES = 15
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  flush,
   input  logic [5:0]                            flush_skip,
   input  logic                                  beat_valid,
   input  logic [8*BEAT_BYTES-1:0]               beat_data,
   output logic                                  beat_ready,
   output logic                                  want_line,
   output logic [8*WINDOW_BYTES-1:0]             window,
   output logic                                  window_valid,
   output logic [$clog2(DEPTH_BYTES):0]          count,
   input  logic [3:0]                            consume,
   output logic                                  err
);

   localparam int PW = $clog2(DEPTH_BYTES);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_BYTES);
   localparam logic [CW-1:0] BEAT_C  = CW'(BEAT_BYTES);
   localparam logic [CW-1:0] LINE_C  = CW'(64);
   localparam logic [CW-1:0] WIN_C   = CW'(WINDOW_BYTES);
   localparam logic [5:0]    BEAT_S  = 6'(BEAT_BYTES);

   logic [7:0]    mem [DEPTH_BYTES];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count_q;
   logic [5:0]    skip_rem;
   logic          err_q;

   logic [CW-1:0] free_bytes;
   logic          accept;
   logic          partial;
   logic [CW-1:0] n_enq;
   logic [CW-1:0] cons_ext;
   logic          over;
   logic [CW-1:0] cons_eff;

   // Ready depends only on registered state: room for a whole beat, or the
   // beat would be swallowed entirely by the skip counter.
   assign free_bytes = DEPTH_C - count_q;
   assign beat_ready = (free_bytes >= BEAT_C) | (skip_rem >= BEAT_S);
   assign want_line  = (free_bytes >= LINE_C);
   assign accept     = beat_valid & beat_ready;
   assign partial    = skip_rem < BEAT_S;
   assign cons_ext   = CW'(consume);
   assign over       = cons_ext > count_q;
   assign cons_eff   = over ? count_q : cons_ext;

   // Bytes actually enqueued by this cycle's beat after skipping.
   always_comb begin
      n_enq = '0;
      if (accept && partial)
         n_enq = BEAT_C - CW'(skip_rem);
   end

   // Pointer, count, skip and error state; flush wins over beat and consume.
   always_ff @(posedge clk) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count_q  <= '0;
         skip_rem <= '0;
         err_q    <= 1'b0;
      end else if (flush) begin
         head     <= '0;
         tail     <= '0;
         count_q  <= '0;
         skip_rem <= flush_skip;
      end else begin
         if (accept)
            skip_rem <= partial ? 6'd0 : skip_rem - BEAT_S;
         tail    <= tail + PW'(n_enq);
         head    <= head + PW'(cons_eff);
         count_q <= count_q + n_enq - cons_eff;
         if (over)
            err_q <= 1'b1;
      end
   end

   // Byte storage: surviving beat bytes are packed contiguously from tail.
   always_ff @(posedge clk) begin
      if (!reset && !flush && accept && partial) begin
         for (int j = 0; j < BEAT_BYTES; j++) begin
            if (6'(j) >= skip_rem)
               mem[tail + PW'(j) - PW'(skip_rem)] <= beat_data[8*j +: 8];
         end
      end
   end

   // Window view: pointer arithmetic wraps naturally at the array end;
   // bytes beyond the held count read as zero.
   for (genvar k = 0; k < WINDOW_BYTES; k++) begin : g_win
      logic [PW-1:0] idx;
      assign idx = head + PW'(k);
      assign window[8*k +: 8] = (CW'(k) < count_q) ? mem[idx] : 8'h00;
   end

   assign window_valid = (count_q >= WIN_C);
   assign count        = count_q;
   assign err          = err_q;

endmodule
